ghost_mover: RTL
================

# ghost_mover

Generates the playfield positions of the four ghosts (red, pink, blue, orange) and feeds the `x_*`/`y_*` coordinate inputs of the enemy sprite renderer. Positions update once per movement step, during vertical blank, so a frame is never drawn with half-updated coordinates. Each ghost carries a direction register and moves one pixel per step inside a rectangular play area. At walls and periodic turn points, a new direction is chosen from a shared LFSR.

## Interface
- `X_MAX`, default 248: largest legal ghost x (screen width 256 minus 8-px sprite).
- `Y_MAX`, default 280: largest legal ghost y. Minimum is 0 on both axes.
- `SPEED_DIV`, default 2: frame ticks per movement step (1..15).
- `TURN_PERIOD`, default 16: steps between forced turn decisions (2..255).
- `START_X`, default {120,104,120,136}: respawn x for red, pink, blue, orange (packed 4×9 bits).
- `START_Y`, default {112,136,136,136}: respawn y for red, pink, blue, orange (packed 4×9 bits).
- `clk` input 1: system/pixel clock.
- `rst` input 1: reset, asynchronous, active-low.
- `frame_tick` input 1: one-cycle pulse at start of vertical blank.
- `run` input 1: 1 = ghosts move; 0 = positions and step counter frozen.
- `respawn` input 1: one-cycle pulse; returns all ghosts to their start positions.
- `pac_x`, `pac_y` input 9 each: player position (used only with chase enabled).
- `x_red`, `y_red`, `x_pink`, `y_pink`, `x_blue`, `y_blue`, `x_orange`, `y_orange` output 9 each: registered ghost top-left coordinates.
- `busy` output 1: high while the update sequence is running.

## Operation
- **Reset** (`rst`=0): positions = `START_X`/`START_Y`. Directions are red LEFT, pink UP, blue UP, orange RIGHT. `step_cnt`=0, `turn_cnt`=0, LFSR=16'hACE1, state IDLE, `busy`=0.
- **LFSR**: 16-bit Galois, mask 16'hB400, advances every clock. It is never all-zero.
- **FSM states**: IDLE, UPDATE.
- **IDLE**: on `frame_tick`&&`run`, `step_cnt` increments.
  - If `step_cnt`==`SPEED_DIV`-1: clear `step_cnt`, increment `turn_cnt` (wrapping at `TURN_PERIOD`), set idx=0, go to UPDATE.
- **UPDATE**: processes one ghost per cycle in the order red, pink, blue, orange, then returns to IDLE.
- **Per-ghost update**:
  - Compute next = pos ±1 along the current direction (UP: y-1, DOWN: y+1, LEFT: x-1, RIGHT: x+1).
  - Blocked if next would be <0 or >`X_MAX`/`Y_MAX`. Detect this before the subtraction, so there is no wrap.
  - If blocked: the position holds, and the new direction = `lfsr[1:0]`. If that value equals the blocked direction, use the opposite direction instead.
  - Else, if `turn_cnt`==0: move, and the new direction = `lfsr[1:0]`. If that is the reverse of the current direction, keep the current direction.
  - Otherwise: move, and keep the direction.
- **respawn**: takes priority over everything. Restores reset positions and directions, clears both counters, and forces IDLE. The LFSR is not reset.
- `frame_tick` during UPDATE is ignored; `step_cnt` is not advanced.
- `run`=0 in the middle of UPDATE: the sequence completes, then freezes.

## Timing
- Ghost i (0 = red … 3 = orange) output changes on clock edge tick+1+i. All four are stable 4 cycles after the step tick, well inside blanking.
- `busy` is high for exactly 4 cycles per step.
- Outputs are registered with no combinational path from inputs. Reset is asynchronous-assert; release is synchronised externally.

## Configuration
- `GHOST_CHASE_EN`, defined: for red only, turn and blocked decisions pick the axis with the larger |pac − ghost| distance, moving toward pac.
  - If that move is blocked, it falls back to the LFSR rule.
  - Ties choose the x axis.
- Undefined: `pac_x`/`pac_y` are unused (lint-waived) and all ghosts use the LFSR rule.

## Structure
- Shared package `pacman_pkg`:
  - `dir_t` enum (UP=0, RIGHT=1, DOWN=2, LEFT=3) and an `opposite()` function.
  - Ghost index constants `GHOST_RED..GHOST_ORANGE`.
  - `SPRITE_W`/`SPRITE_H`=8.
- One sub-module: `lfsr16` (clk, rst, q[15:0]).
- Position and direction are held in 4-entry arrays indexed by idx.

## Test plan
- Reset, then 2 frame ticks with `run`=1: red goes 120→119 at cycle tick+1, pink y goes 136→135 at tick+2; `busy` is high for 4 cycles.
- Start red at x=0 moving LEFT, one step: x stays 0 and the direction becomes something other than LEFT.
- Orange at x=248 moving RIGHT, one step: x stays 248 and x never reads 249 in the trace.
- `run`=0 for 10 frame ticks: all 8 outputs are unchanged and `busy` stays 0.
- `respawn` asserted together with a step-completing `frame_tick`: all outputs equal START values next cycle and no UPDATE occurs.
- With `GHOST_CHASE_EN`, red at (120,112), pac at (40,112), turn step: red direction becomes LEFT and x decrements on following steps.

Source files
------------

// File: rtl/pacman_pkg.sv
// pacman_pkg: shared ghost direction/state types, ghost indices and sprite geometry.
package pacman_pkg;
  typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;
  typedef enum logic {IDLE, UPDATE} state_t;
  localparam logic [1:0] GHOST_RED = 2'd0;
  localparam logic [1:0] GHOST_PINK = 2'd1;
  localparam logic [1:0] GHOST_BLUE = 2'd2;
  localparam logic [1:0] GHOST_ORANGE = 2'd3;
  localparam int SPRITE_W = 8;
  localparam int SPRITE_H = 8;
  // Opposite directions differ only in bit 1 of the encoding.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({~d[1], d[0]});
  endfunction
endpackage

// File: rtl/ghost_mover_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (mask 16'hB400), seeded to 16'hACE1.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 16'hACE1;
    else q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
endmodule

// File: rtl/ghost_mover.sv
// ghost_mover: four-ghost position sequencer updated once per movement step in vblank.
// Optional GHOST_CHASE_EN makes red steer toward the player on turn/blocked decisions.
module ghost_mover
  import pacman_pkg::*;
#(
  parameter int          X_MAX       = 248,
  parameter int          Y_MAX       = 280,
  parameter int          SPEED_DIV   = 2,
  parameter int          TURN_PERIOD = 16,
  parameter logic [35:0] START_X     = {9'd120, 9'd104, 9'd120, 9'd136},
  parameter logic [35:0] START_Y     = {9'd112, 9'd136, 9'd136, 9'd136}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       respawn,
  input  logic [8:0] pac_x,
  input  logic [8:0] pac_y,
  output logic [8:0] x_red,
  output logic [8:0] y_red,
  output logic [8:0] x_pink,
  output logic [8:0] y_pink,
  output logic [8:0] x_blue,
  output logic [8:0] y_blue,
  output logic [8:0] x_orange,
  output logic [8:0] y_orange,
  output logic       busy
);
  logic [15:0] lfsr;
  state_t state;
  logic [1:0] idx;
  logic [3:0] step_cnt;
  logic [7:0] turn_cnt;
  logic [8:0] pos_x [4];
  logic [8:0] pos_y [4];
  dir_t dir [4];
  logic [8:0] cx, cy, nx, ny;
  dir_t cd, rnd, ld, nd;
  logic blk, turn;
  logic unused;

  lfsr16 u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

  function automatic dir_t home_dir(input int i);
    return i == 0 ? LEFT : i == 3 ? RIGHT : UP;
  endfunction

  // Checked before any arithmetic so an edge position never wraps.
  function automatic logic blocked(input dir_t d, input logic [8:0] x, input logic [8:0] y);
    return d == UP ? y == 9'd0 : d == DOWN ? y >= 9'(Y_MAX) : d == LEFT ? x == 9'd0 : x >= 9'(X_MAX);
  endfunction

  always_comb begin
    cx = pos_x[idx];
    cy = pos_y[idx];
    cd = dir[idx];
    rnd = dir_t'(lfsr[1:0]);
    blk = blocked(cd, cx, cy);
    turn = turn_cnt == 8'd0;
    nx = blk ? cx : cd == LEFT ? cx - 9'd1 : cd == RIGHT ? cx + 9'd1 : cx;
    ny = blk ? cy : cd == UP ? cy - 9'd1 : cd == DOWN ? cy + 9'd1 : cy;
    ld = blk ? (rnd == cd ? opposite(cd) : rnd) : turn ? (rnd == opposite(cd) ? cd : rnd) : cd;
    nd = ld;
  end

`ifdef GHOST_CHASE_EN
  logic [8:0] dx, dy;
  dir_t chase, nd_chase;
  always_comb begin
    dx = pac_x >= cx ? pac_x - cx : cx - pac_x;
    dy = pac_y >= cy ? pac_y - cy : cy - pac_y;
    chase = dx >= dy ? (pac_x < cx ? LEFT : RIGHT) : (pac_y < cy ? UP : DOWN);
    nd_chase = (idx == GHOST_RED && (blk || turn) && !blocked(chase, cx, cy)) ? chase : nd;
  end
  assign unused = ^lfsr[15:2];
`else
  dir_t nd_chase;
  assign nd_chase = nd;
  assign unused = ^{lfsr[15:2], pac_x, pac_y};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= 2'd0;
      step_cnt <= 4'd0;
      turn_cnt <= 8'd0;
      busy <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pos_x[i] <= START_X[(3 - i) * 9 +: 9];
        pos_y[i] <= START_Y[(3 - i) * 9 +: 9];
        dir[i] <= home_dir(i);
      end
    end else if (respawn) begin
      state <= IDLE;
      idx <= 2'd0;
      step_cnt <= 4'd0;
      turn_cnt <= 8'd0;
      busy <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pos_x[i] <= START_X[(3 - i) * 9 +: 9];
        pos_y[i] <= START_Y[(3 - i) * 9 +: 9];
        dir[i] <= home_dir(i);
      end
    end else if (state == IDLE) begin
      if (frame_tick && run) begin
        if (step_cnt == 4'(SPEED_DIV - 1)) begin
          step_cnt <= 4'd0;
          turn_cnt <= turn_cnt == 8'(TURN_PERIOD - 1) ? 8'd0 : turn_cnt + 8'd1;
          idx <= 2'd0;
          state <= UPDATE;
          busy <= 1'b1;
        end else begin
          step_cnt <= step_cnt + 4'd1;
        end
      end
    end else begin
      pos_x[idx] <= nx;
      pos_y[idx] <= ny;
      dir[idx] <= nd_chase;
      idx <= idx + 2'd1;
      if (idx == GHOST_ORANGE) begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
  end

  assign x_red = pos_x[0];
  assign y_red = pos_y[0];
  assign x_pink = pos_x[1];
  assign y_pink = pos_y[1];
  assign x_blue = pos_x[2];
  assign y_blue = pos_y[2];
  assign x_orange = pos_x[3];
  assign y_orange = pos_y[3];
endmodule
